fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 22 ++
 rtl/adder_16bit.sv | 10 +
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions for the fetch controller: state encoding, opcode
// constants and small address helpers.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_MISS_WAIT = 2'b01,
        ST_HALT      = 2'b10
    } fetch_state_e;

    localparam logic [3:0]  OP_NOP        = 4'b0000;
    localparam logic [3:0]  OP_HLT        = 4'b1111;
    localparam logic [15:0] PC_RESET      = 16'h0000;
    localparam logic [15:0] PC_STEP       = 16'h0002;
    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // Instructions are 16-bit, so fetch addresses are always halfword aligned.
    function automatic logic [15:0] align_half(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/adder_16bit.sv
// Plain 16-bit adder, wraps modulo 2^16.
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: sequential fetch, branch redirect, decode stalls,
// instruction-cache miss wait and sticky halt.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        stall_id,
    input  logic        halt_id,
    input  logic        icache_miss,
    input  logic        icache_valid,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        imem_req,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [1:0]  state_dbg
);

    // Cache handshake: imem_req asks for the word at pc; icache_miss in RUN
    // means it is not available this cycle. In MISS_WAIT pc is held until the
    // cycle icache_valid is high, which is the cycle the word is delivered.

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  redirect_q, redirect_d;
    logic         redirect_pend_q, redirect_pend_d;
    logic         halted_q, halted_d;
    logic [15:0]  stall_cnt_q, stall_cnt_d;
    logic         stall_inc;
    logic         imem_req_c, if_id_write_c, if_id_flush_c;
    logic [15:0]  pc_inc;

    adder_16bit u_pc_adder (
        .a   (pc_q),
        .b   (PC_STEP),
        .sum (pc_inc)
    );

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        redirect_d      = redirect_q;
        redirect_pend_d = redirect_pend_q;
        halted_d        = halted_q;
        stall_inc       = 1'b0;
        imem_req_c      = 1'b0;
        if_id_write_c   = 1'b0;
        if_id_flush_c   = 1'b0;

        case (state_q)
            ST_RUN: begin
                imem_req_c = 1'b1;
                if (halt_id) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (branch_taken && !stall_id) begin
                    if_id_flush_c = 1'b1;
                    if (icache_miss) begin
                        // Target is parked until the outstanding fill completes.
                        redirect_d      = align_half(branch_target);
                        redirect_pend_d = 1'b1;
                        state_d         = ST_MISS_WAIT;
                    end else begin
                        pc_d = align_half(branch_target);
                    end
                end else if (stall_id) begin
                    stall_inc = 1'b1;
                end else if (icache_miss) begin
                    if_id_flush_c = 1'b1;
                    state_d       = ST_MISS_WAIT;
                end else begin
                    if_id_write_c = 1'b1;
                    pc_d          = pc_inc;
                end
            end
            ST_MISS_WAIT: begin
                imem_req_c = 1'b1;
                stall_inc  = 1'b1;
                if (icache_valid) begin
                    state_d = ST_RUN;
                    if (redirect_pend_q) begin
                        if_id_flush_c   = 1'b1;
                        pc_d            = redirect_q;
                        redirect_pend_d = 1'b0;
                    end else begin
                        if_id_write_c = 1'b1;
                        pc_d          = pc_inc;
                    end
                end else begin
                    if_id_flush_c = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            pc_q            <= PC_RESET;
            redirect_q      <= PC_RESET;
            redirect_pend_q <= 1'b0;
            halted_q        <= 1'b0;
            stall_cnt_q     <= 16'h0000;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            redirect_q      <= redirect_d;
            redirect_pend_q <= redirect_pend_d;
            halted_q        <= halted_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    // Strobes are forced low while reset is held, whatever the stale state is.
    assign imem_req    = rst_n & imem_req_c;
    assign if_id_write = rst_n & if_id_write_c;
    assign if_id_flush = rst_n & if_id_flush_c;
    assign pc          = pc_q;
    assign pc_plus2    = pc_inc;
    assign halted      = halted_q;
    assign stall_cnt   = stall_cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a cycle-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        stall_id;
    logic        halt_id;
    logic        icache_miss;
    logic        icache_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        imem_req;
    logic        if_id_write;
    logic        if_id_flush;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall_id      (stall_id),
        .halt_id       (halt_id),
        .icache_miss   (icache_miss),
        .icache_valid  (icache_valid),
        .pc            (pc),
        .pc_plus2      (pc_plus2),
        .imem_req      (imem_req),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_pc;
    logic [15:0] m_cnt;
    logic [15:0] m_redir;
    bit          m_redir_v;
    bit          m_waiting;
    bit          m_halted;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 16'h0000; m_cnt = 16'h0000; m_redir = 16'h0000;
            m_redir_v = 0; m_waiting = 0; m_halted = 0;
        end else if (m_halted) begin
            m_pc = m_pc;
        end else if (m_waiting) begin
            m_cnt = sat_inc(m_cnt);
            if (icache_valid) begin
                m_waiting = 0;
                if (m_redir_v) begin
                    m_pc = m_redir;
                    m_redir_v = 0;
                end else begin
                    m_pc = m_pc + 16'd2;
                end
            end
        end else if (halt_id) begin
            m_halted = 1;
        end else if (branch_taken && !stall_id) begin
            if (icache_miss) begin
                m_redir = branch_target & 16'hFFFE;
                m_redir_v = 1;
                m_waiting = 1;
            end else begin
                m_pc = branch_target & 16'hFFFE;
            end
        end else if (stall_id) begin
            m_cnt = sat_inc(m_cnt);
        end else if (icache_miss) begin
            m_waiting = 1;
        end else begin
            m_pc = m_pc + 16'd2;
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic e_req, e_wr, e_fl;
        logic [1:0] e_st;
        if (check_en) begin
            e_req = 0; e_wr = 0; e_fl = 0;
            if (!rst_n || m_halted) begin
                e_req = 0;
            end else if (m_waiting) begin
                e_req = 1;
                if (!icache_valid) e_fl = 1;
                else if (m_redir_v) e_fl = 1;
                else e_wr = 1;
            end else begin
                e_req = 1;
                if (halt_id) e_wr = 0;
                else if (branch_taken && !stall_id) e_fl = 1;
                else if (stall_id) e_wr = 0;
                else if (icache_miss) e_fl = 1;
                else e_wr = 1;
            end
            e_st = m_halted ? 2'd2 : (m_waiting ? 2'd1 : 2'd0);
            check16("pc", pc, m_pc);
            check16("pc_plus2", pc_plus2, m_pc + 16'd2);
            check16("imem_req", {15'd0, imem_req}, {15'd0, e_req});
            check16("if_id_write", {15'd0, if_id_write}, {15'd0, e_wr});
            check16("if_id_flush", {15'd0, if_id_flush}, {15'd0, e_fl});
            check16("halted", {15'd0, halted}, {15'd0, m_halted});
            check16("stall_cnt", stall_cnt, m_cnt);
            check16("state", {14'd0, state_dbg}, {14'd0, e_st});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        branch_taken = 0; branch_target = 16'h0000; stall_id = 0;
        halt_id = 0; icache_miss = 0; icache_valid = 0;
    endtask

    task automatic branch_to(input logic [15:0] tgt);
        branch_taken = 1; branch_target = tgt;
        tick();
        branch_taken = 0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 0;
        idle_inputs();
        tick();
        check_en = 1;
        tick();
        #1;
        check16("rst_pc", pc, 16'h0000);
        check16("rst_halted", {15'd0, halted}, 16'd0);
        check16("rst_cnt", stall_cnt, 16'h0000);
        check16("rst_req", {15'd0, imem_req}, 16'd0);
        check16("rst_write", {15'd0, if_id_write}, 16'd0);
        rst_n = 1;
        #1;

        // Sequential fetch from reset.
        for (int i = 0; i < 4; i++) begin
            check16("seq_pc", pc, 16'(2 * i));
            check16("seq_write", {15'd0, if_id_write}, 16'd1);
            tick();
        end
        check16("seq_pc_end", pc, 16'h0008);

        // Walk to 0x0010 and take a misaligned branch.
        repeat (4) tick();
        check16("br_pc_before", pc, 16'h0010);
        branch_taken = 1; branch_target = 16'h0041;
        #1;
        check16("br_flush", {15'd0, if_id_flush}, 16'd1);
        tick();
        branch_taken = 0;
        check16("br_pc_after", pc, 16'h0040);

        // Cache miss at 0x0020: one RUN cycle, three waiting cycles, then fill.
        branch_to(16'h0020);
        icache_miss = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check16("miss_hold", pc, 16'h0020);
            tick();
        end
        icache_miss = 0; icache_valid = 1;
        #1;
        check16("miss_fill_write", {15'd0, if_id_write}, 16'd1);
        tick();
        icache_valid = 0;
        check16("miss_cnt", stall_cnt, 16'd4);
        check16("miss_pc_after", pc, 16'h0022);

        // Branch coincident with a miss: target applied on the fill cycle.
        branch_taken = 1; branch_target = 16'h0100; icache_miss = 1;
        #1;
        check16("redir_flush_now", {15'd0, if_id_flush}, 16'd1);
        tick();
        branch_taken = 0; icache_miss = 0;
        repeat (2) tick();
        check16("redir_hold", pc, 16'h0022);
        icache_valid = 1;
        #1;
        check16("redir_fill_flush", {15'd0, if_id_flush}, 16'd1);
        tick();
        icache_valid = 0;
        check16("redir_pc", pc, 16'h0100);
        check16("redir_cnt", stall_cnt, 16'd7);

        // Stall outranks a branch; decode re-presents it afterwards.
        stall_id = 1; branch_taken = 1; branch_target = 16'h0200;
        #1;
        check16("stall_flush", {15'd0, if_id_flush}, 16'd0);
        tick();
        stall_id = 0; branch_taken = 0;
        check16("stall_pc", pc, 16'h0100);
        check16("stall_cnt1", stall_cnt, 16'd8);

        // Halt at 0x0030; branches afterwards are ignored.
        branch_to(16'h0030);
        halt_id = 1;
        tick();
        halt_id = 0;
        branch_taken = 1; branch_target = 16'h1234;
        repeat (5) tick();
        branch_taken = 0;
        check16("halt_pc", pc, 16'h0030);
        check16("halt_flag", {15'd0, halted}, 16'd1);
        check16("halt_req", {15'd0, imem_req}, 16'd0);
        rst_n = 0;
        tick();
        rst_n = 1;
        check16("halt_rst_pc", pc, 16'h0000);
        check16("halt_rst_flag", {15'd0, halted}, 16'd0);

        // Reset mid-miss discards the pending redirect.
        branch_taken = 1; branch_target = 16'h0500; icache_miss = 1;
        tick();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        check16("rst_miss_pc", pc, 16'h0002);

        // Address wrap at the top of memory.
        branch_to(16'hFFFF);
        check16("wrap_pc", pc, 16'hFFFE);
        check16("wrap_plus2", pc_plus2, 16'h0000);
        tick();
        check16("wrap_pc_after", pc, 16'h0000);

        // Saturate the stall counter.
        stall_id = 1;
        for (int i = 0; i < 65540; i++) tick();
        check16("sat_cnt", stall_cnt, 16'hFFFF);
        tick();
        check16("sat_cnt_hold", stall_cnt, 16'hFFFF);
        stall_id = 0;
        tick();

        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
